mdc_seq: RTL
============

Name: mdc_seq

Overview:
- Initiator/sequencer for the GCD (MDC) core.
- Accepts operand pairs over a valid/ready command stream and buffers them in a small FIFO.
- Launches one job at a time into the core using its start/busy/done handshake, and returns results on a valid/ready result stream.
- Handles zero operands locally, because the subtract-loop core never terminates on them. Guards each job with a watchdog.

Parameters:
- WIDTH, 8, operand/result bit width
- DEPTH, 4, command FIFO entries (power of 2, >=2)
- TIMEOUT, 1024, max cycles in WAIT before a job is aborted

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- cmd_valid_i  in  1  operand pair valid
- cmd_ready_o  out  1  FIFO not full
- cmd_x_i  in  WIDTH  operand x
- cmd_y_i  in  WIDTH  operand y
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result consumer ready
- res_data_o  out  WIDTH  gcd result
- mdc_start_o  out  1  to core enb_i, one-cycle pulse
- mdc_x_o  out  WIDTH  operand x to core, registered
- mdc_y_o  out  WIDTH  operand y to core, registered
- mdc_busy_i  in  1  core busy_o
- mdc_done_i  in  1  core enb_o, one-cycle pulse, result valid
- mdc_result_i  in  WIDTH  core result
- err_o  out  1  sticky watchdog error

Behaviour:
- Interface: one clock (clk); reset rst_i is synchronous, active-high.
- Reset values:
  - mdc_start_o=0, mdc_x_o=0, mdc_y_o=0
  - res_valid_o=0, res_data_o=0, err_o=0
  - FIFO empty, state IDLE, watchdog counter 0
  - Reset mid-job abandons the job silently. Reset also returns the core to S0, since both share rst.
- Command FIFO:
  - Push when cmd_valid_i && cmd_ready_o.
  - cmd_ready_o = !full. Full with simultaneous pop still reports not-ready (no bypass).
  - Head is visible to the FSM the cycle after the push.
- Output slot ("slot free"):
  - Free = !res_valid_o || res_ready_i.
  - res_valid_o holds with res_data_o stable until res_ready_i.
  - Load and drain in the same cycle is allowed.
- FSM states: IDLE, LAUNCH, WAIT.
- IDLE:
  - Acts only when FIFO not empty && slot free && !mdc_busy_i.
  - Zero bypass (x==0 || y==0): pop; res_data_o <= x|y; res_valid_o <= 1; stay in IDLE. Covers gcd(a,0)=a and gcd(0,0)=0.
  - Otherwise: pop; mdc_x_o <= x; mdc_y_o <= y; mdc_start_o <= 1; go to LAUNCH.
- LAUNCH (1 cycle):
  - mdc_start_o=1 with operands stable; the core samples both at this edge.
  - Next cycle mdc_start_o=0; go to WAIT and clear the watchdog.
- WAIT:
  - mdc_x_o/mdc_y_o held stable throughout.
  - On mdc_done_i: res_data_o <= mdc_result_i; res_valid_o <= 1; go to IDLE. The slot is guaranteed free because launch required it.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without done: err_o <= 1 (sticky until reset); no result is emitted; go to IDLE.
  - IDLE will not relaunch while mdc_busy_i=1.
- mdc_done_i outside WAIT is ignored.
- Exactly one job is outstanding. Results are returned in command order.
- Latency, non-zero job accepted at edge N into an empty FIFO, idle core, free slot:
  - pop at N+1, start high in cycle N+1..N+2, WAIT from N+2.
  - res_valid_o high the cycle after the done pulse.
- Latency, bypass job: res_valid_o high after edge N+1.
- Watchdog counter width: $clog2(TIMEOUT+1).

Decomposition:
- Package mdc_pkg:
  - state typedef enum {IDLE, LAUNCH, WAIT}
  - default WIDTH
  - function is_bypass(x,y)
- Sub-module mdc_fifo:
  - Parameters WIDTH*2 and DEPTH.
  - Ports: push, pop, full, empty, head.
  - Pointers with an extra wrap bit.
- FSM, watchdog and result slot live in mdc_seq.

Test Plan:
- Push (12,18) with a behavioural core model (done after 5 cycles, result 6) -> one mdc_start_o pulse carrying x=12, y=18; res_data_o=6 with res_valid_o high until res_ready_i; err_o=0.
- Push (0,7), then (9,0), then (0,0) -> results 7, 9, 0, each one cycle apart with res_ready_i=1; mdc_start_o never asserted.
- res_ready_i=0; push 6 non-zero pairs with DEPTH=4 -> at most one job completes; cmd_ready_o deasserts after the FIFO fills; release ready -> all results return in order, none lost.
- Core model never asserts done, TIMEOUT=16 -> err_o rises 16 cycles into WAIT and stays high; no res_valid_o. Then core busy drops and (8,4) is pushed -> result 4 with err_o still 1.
- Assert rst_i during WAIT with 2 entries queued -> next cycle all outputs are at reset values and the FIFO is empty; a late done pulse produces no result.
- Push (21,14) while mdc_busy_i held high externally -> no start until busy drops, then start within 1 cycle; result 7.

Source files
------------

// File: rtl/mdc_pkg.sv
// Shared types and helpers for the GCD core sequencer.
package mdc_pkg;

    localparam int MDC_WIDTH    = 8;
    localparam int BYPASS_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    // The subtract-loop core never terminates on a zero operand, so those pairs are answered locally.
    function automatic logic is_bypass(input logic [BYPASS_MAX_W-1:0] x,
                                       input logic [BYPASS_MAX_W-1:0] y);
        return (x == '0) || (y == '0);
    endfunction

endpackage

// File: rtl/mdc_fifo.sv
// Command FIFO for operand pairs; pointers carry an extra wrap bit to tell full from empty.
module mdc_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = data_i;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mdc_seq.sv
// Sequencer that feeds queued operand pairs to the GCD core one job at a time.
//   state  | meaning
//   IDLE   | waiting for a queued pair, a free result slot and an idle core
//   LAUNCH | start pulse high, core samples operands at the end of this cycle
//   WAIT   | job running, watchdog counting until done or timeout
module mdc_seq
    import mdc_pkg::*;
#(
    parameter int WIDTH   = MDC_WIDTH,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [WIDTH-1:0] cmd_x_i,
    input  logic [WIDTH-1:0] cmd_y_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] res_data_o,
    output logic             mdc_start_o,
    output logic [WIDTH-1:0] mdc_x_o,
    output logic [WIDTH-1:0] mdc_y_o,
    input  logic             mdc_busy_i,
    input  logic             mdc_done_i,
    input  logic [WIDTH-1:0] mdc_result_i,
    output logic             err_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_TC  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               start_q, start_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               res_valid_q, res_valid_d;
    logic [WIDTH-1:0]   res_data_q, res_data_d;
    logic               err_q, err_d;

    logic               fifo_full;
    logic               fifo_empty;
    logic [2*WIDTH-1:0] fifo_head;
    logic               pop;
    logic [WIDTH-1:0]   head_x;
    logic [WIDTH-1:0]   head_y;
    logic               slot_free;
    logic               launch_ok;
    logic               bypass;
    logic               timeout_hit;

    mdc_fifo #(
        .WIDTH (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_i   (rst_i),
        .push_i  (cmd_valid_i),
        .pop_i   (pop),
        .data_i  ({cmd_x_i, cmd_y_i}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign head_x      = fifo_head[2*WIDTH-1:WIDTH];
    assign head_y      = fifo_head[WIDTH-1:0];
    assign slot_free   = !res_valid_q || res_ready_i;
    assign launch_ok   = !fifo_empty && slot_free && !mdc_busy_i;
    assign bypass      = is_bypass(BYPASS_MAX_W'(head_x), BYPASS_MAX_W'(head_y));
    assign timeout_hit = (cnt_q == CNT_TC);

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            start_q     <= start_d;
            x_q         <= x_d;
            y_q         <= y_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch_ok && !bypass) state_d = LAUNCH;
            LAUNCH:  state_d = WAIT;
            WAIT:    if (mdc_done_i || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop         = 1'b0;
        start_d     = 1'b0;
        x_d         = x_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q && !res_ready_i;
        res_data_d  = res_data_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (launch_ok) begin
                    pop = 1'b1;
                    if (bypass) begin
                        res_data_d  = head_x | head_y;
                        res_valid_d = 1'b1;
                    end else begin
                        x_d     = head_x;
                        y_d     = head_y;
                        start_d = 1'b1;
                    end
                end
            end
            LAUNCH: cnt_d = '0;
            WAIT: begin
                // Launch required a free slot, so nothing can be pending here.
                if (mdc_done_i) begin
                    res_data_d  = mdc_result_i;
                    res_valid_d = 1'b1;
                end else if (timeout_hit) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: ;
        endcase
    end

    assign cmd_ready_o = !fifo_full;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign mdc_start_o = start_q;
    assign mdc_x_o     = x_q;
    assign mdc_y_o     = y_q;
    assign err_o       = err_q;

endmodule
